// File: rtl/aes256_pkg.sv
// Shared AES-256 key-schedule constants: geometry, Rcon, the S-box lookup and FSM state encoding.
package aes256_pkg;

  localparam int NUM_ROUNDS = 14;
  localparam int NUM_KEYS   = 15;
  localparam int NUM_WORDS  = 60;
  localparam int BLK_W      = 128;
  localparam int KEY_W      = 256;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_EMIT = 1'b1;

  // Round constant for words i%8==0; index n = i/8, valid range 1..7.
  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Entry 0x00 sits in the top byte, so byte b lives at bit offset 8*(255-b).
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv_b;
    inv_b = ~b;
    return SBOX_TABLE[{inv_b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes256_subword.sv
// SubWord: four parallel combinational AES S-boxes on a 32-bit word.
module aes256_subword
  import aes256_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes256_key_expand.sv
// AES-256 key expansion streaming one 128-bit round key per handshake from a sliding 256-bit window.
module aes256_key_expand
  import aes256_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [255:0] key_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   w_q, w_d;
  logic [BLK_W-1:0]   rk_q, rk_d;
  logic [3:0]         idx_q, idx_d;
  logic               rk_valid_q, rk_valid_d;
  logic               done_q, done_d;

  logic               rot_step;
  logic [3:0]         rcon_idx;
  logic [31:0]        temp_in, sub_out, temp;
  logic [31:0]        c0, c1, c2, c3;
  logic               handshake;

  // Odd idx means the next round key starts at a word index divisible by 8.
  assign rot_step = idx_q[0];
  assign rcon_idx = (idx_q + 4'd1) >> 1;
  assign temp_in  = rot_step ? {w_q[23:0], w_q[31:24]} : w_q[31:0];

  aes256_subword u_subword (
    .word_i (temp_in),
    .word_o (sub_out)
  );

  assign temp = rot_step ? (sub_out ^ {rcon(rcon_idx), 24'h000000}) : sub_out;
  assign c0   = w_q[255:224] ^ temp;
  assign c1   = w_q[223:192] ^ c0;
  assign c2   = w_q[191:160] ^ c1;
  assign c3   = w_q[159:128] ^ c2;

  assign handshake = rk_valid_q & rk_ready_i;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    rk_d       = rk_q;
    idx_d      = idx_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid_i) begin
          w_d        = key_i;
          rk_d       = key_i[255:128];
          idx_d      = 4'd0;
          rk_valid_d = 1'b1;
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (handshake) begin
          if (idx_q == 4'(NUM_ROUNDS)) begin
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else if (idx_q == 4'd0) begin
            rk_d  = w_q[127:0];
            idx_d = 4'd1;
          end else begin
            rk_d  = {c0, c1, c2, c3};
            w_d   = {w_q[127:0], c0, c1, c2, c3};
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      rk_q       <= '0;
      idx_q      <= 4'd0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      rk_q       <= rk_d;
      idx_q      <= idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign key_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_EMIT);
  assign rk_o        = rk_q;
  assign rk_idx_o    = idx_q;
  assign rk_valid_o  = rk_valid_q;
  assign done_o      = done_q;

endmodule
